// File: rtl/dpcm_encoder.sv
// 4-bit differential PCM encoder: each accepted sample produces the wrap-around
// difference from the previously accepted sample. Accepts at most one sample every two clocks.
module dpcm_encoder #(
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data,
    output logic              in_ready,
    output logic [DATA_W-1:0] out,
    output logic [1:0]        dbg_state_o,
    output logic [DATA_W-1:0] dbg_pred_o
);

    // Handshake: a sample is consumed at a rising edge where in_valid and in_ready
    // are both high; upstream holds data stable until then. in_ready is a register,
    // so it never depends combinationally on in_valid or data.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pred_q, pred_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              ready_q, ready_d;
    logic              take;

    assign take = in_valid && ready_q;

    always_comb begin
        state_d = state_q;
        pred_d  = pred_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE:   state_d = ACCEPT;
            ACCEPT: begin
                if (take) begin
                    out_d   = data - pred_q;
                    pred_d  = data;
                    state_d = HOLD;
                end
            end
            HOLD:   state_d = ACCEPT;
            default: state_d = IDLE;
        endcase
        // Ready is registered from the next state so it is true exactly in ACCEPT.
        ready_d = (state_d == ACCEPT);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pred_q  <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pred_q  <= pred_d;
            out_q   <= out_d;
            ready_q <= ready_d;
        end
    end

    assign in_ready    = ready_q;
    assign out         = out_q;
    assign dbg_state_o = state_q;
    assign dbg_pred_o  = pred_q;

endmodule

// File: tb/tb_dpcm_encoder.sv
// Self-checking bench for dpcm_encoder: directed vector table, hand-written
// reset/wrap sequences, then random traffic against a behavioural model.
module tb_dpcm_encoder;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [3:0] data;
    logic       in_ready;
    logic [3:0] out;
    logic [1:0] dbg_state_o;
    logic [3:0] dbg_pred_o;

    int checks = 0;
    int errors = 0;

    dpcm_encoder #(.DATA_W(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .data        (data),
        .in_ready    (in_ready),
        .out         (out),
        .dbg_state_o (dbg_state_o),
        .dbg_pred_o  (dbg_pred_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       v;
        logic [3:0] d;
        logic       r;
        logic [3:0] o;
        logic [3:0] p;
    } vec_t;

    vec_t vecs[22];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic step(input logic v, input logic [3:0] d);
        in_valid = v;
        data     = d;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        data     = 4'h0;
        repeat (3) begin
            @(negedge clock);
            chk("reset_ready", {7'd0, in_ready}, 8'd0);
            chk("reset_out", {4'd0, out}, 8'd0);
        end
        reset = 1'b1;
    endtask

    // Behavioural model: the block alternates accepts with one dead cycle,
    // and out is the wrap-around difference of the last two accepted samples.
    logic       m_ready;
    logic [3:0] m_pred;
    logic [3:0] m_out;

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        data     = 4'h0;

        vecs[0]  = '{1'b1, 4'h1, 1'b1, 4'h0, 4'h0};
        vecs[1]  = '{1'b1, 4'h1, 1'b0, 4'h1, 4'h1};
        vecs[2]  = '{1'b1, 4'h3, 1'b1, 4'h1, 4'h1};
        vecs[3]  = '{1'b1, 4'h3, 1'b0, 4'h2, 4'h3};
        vecs[4]  = '{1'b1, 4'h2, 1'b1, 4'h2, 4'h3};
        vecs[5]  = '{1'b1, 4'h2, 1'b0, 4'hF, 4'h2};
        vecs[6]  = '{1'b1, 4'h2, 1'b1, 4'hF, 4'h2};
        vecs[7]  = '{1'b1, 4'h2, 1'b0, 4'h0, 4'h2};
        vecs[8]  = '{1'b1, 4'hF, 1'b1, 4'h0, 4'h2};
        vecs[9]  = '{1'b1, 4'hF, 1'b0, 4'hD, 4'hF};
        vecs[10] = '{1'b1, 4'h0, 1'b1, 4'hD, 4'hF};
        vecs[11] = '{1'b1, 4'h0, 1'b0, 4'h1, 4'h0};
        vecs[12] = '{1'b1, 4'h5, 1'b1, 4'h1, 4'h0};
        vecs[13] = '{1'b1, 4'h5, 1'b0, 4'h5, 4'h5};
        vecs[14] = '{1'b0, 4'h5, 1'b1, 4'h5, 4'h5};
        vecs[15] = '{1'b0, 4'h5, 1'b1, 4'h5, 4'h5};
        vecs[16] = '{1'b0, 4'h5, 1'b1, 4'h5, 4'h5};
        vecs[17] = '{1'b0, 4'h5, 1'b1, 4'h5, 4'h5};
        vecs[18] = '{1'b1, 4'h7, 1'b0, 4'h2, 4'h7};
        vecs[19] = '{1'b1, 4'h9, 1'b1, 4'h2, 4'h7};
        vecs[20] = '{1'b0, 4'h9, 1'b1, 4'h2, 4'h7};
        vecs[21] = '{1'b0, 4'h0, 1'b1, 4'h2, 4'h7};

        do_reset();
        for (int i = 0; i < 22; i++) begin
            step(vecs[i].v, vecs[i].d);
            chk($sformatf("vec%0d_ready", i), {7'd0, in_ready}, {7'd0, vecs[i].r});
            chk($sformatf("vec%0d_out", i), {4'd0, out}, {4'd0, vecs[i].o});
            chk($sformatf("vec%0d_pred", i), {4'd0, dbg_pred_o}, {4'd0, vecs[i].p});
        end

        // Asynchronous reset between edges after accepting 0xA.
        do_reset();
        step(1'b1, 4'hA);
        step(1'b1, 4'hA);
        chk("mid_accept_out", {4'd0, out}, 8'h0A);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_out", {4'd0, out}, 8'h00);
        chk("async_ready", {7'd0, in_ready}, 8'd0);
        chk("async_pred", {4'd0, dbg_pred_o}, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        step(1'b1, 4'h3);
        chk("post_reset_ready", {7'd0, in_ready}, 8'd1);
        step(1'b1, 4'h3);
        chk("post_reset_out", {4'd0, out}, 8'h03);

        // Wrap extremes from a fresh predictor.
        do_reset();
        step(1'b1, 4'h0);
        step(1'b1, 4'h0);
        chk("wrap0_out", {4'd0, out}, 8'h00);
        step(1'b1, 4'hF);
        step(1'b1, 4'hF);
        chk("wrapF_out", {4'd0, out}, 8'h0F);
        step(1'b1, 4'h0);
        step(1'b1, 4'h0);
        chk("wrap1_out", {4'd0, out}, 8'h01);

        // Random traffic against the model.
        do_reset();
        m_ready = 1'b0;
        m_pred  = 4'h0;
        m_out   = 4'h0;
        for (int n = 0; n < 400; n++) begin
            logic       v;
            logic [3:0] d;
            v = ($urandom_range(0, 3) != 0);
            d = 4'($urandom_range(0, 15));
            step(v, d);
            if (m_ready && v) begin
                m_out   = 4'((d - m_pred) & 4'hF);
                m_pred  = d;
                m_ready = 1'b0;
            end else begin
                m_ready = 1'b1;
            end
            chk("rand_ready", {7'd0, in_ready}, {7'd0, m_ready});
            chk("rand_out", {4'd0, out}, {4'd0, m_out});
            chk("rand_pred", {4'd0, dbg_pred_o}, {4'd0, m_pred});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
